// File: rtl/dfd_trace_arb_pkg.sv
// Shared types and helpers for the trace-output arbiter and its flush sequencers.
package dfd_trace_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    WAIT  = 3'd4
  } flush_state_e;

  localparam int unsigned MAX_TRACE_SRC = 8;

  // Source-id width; a 1-bit id is kept even for degenerate counts.
  function automatic int unsigned src_id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dfd_trace_flush_seq.sv
// Per-source flush/stop sequencer: walks a source generator through flush, drain and completion.
module dfd_trace_flush_seq
  import dfd_trace_arb_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic net_flush,
  input  logic net_bp,
  input  logic src_req,
  input  logic beat_held,
  output logic hw_flush,
  output logic hw_stop,
  output logic flush_done,
  output logic flush_active_c
);

  flush_state_e state;
  logic         draining;

  assign draining       = (state == FLUSH) || (state == DRAIN);
  assign flush_active_c = draining;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      hw_flush   <= 1'b0;
      hw_stop    <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      // Backpressure turns a flush into a stop, so the two are mutually exclusive.
      hw_flush   <= draining & ~net_bp;
      hw_stop    <= draining & net_bp;
      case (state)
        IDLE: begin
          if (net_flush) state <= FLUSH;
        end
        FLUSH: begin
          if (!net_flush)    state <= IDLE;
          else if (!src_req) state <= DRAIN;
        end
        DRAIN: begin
          if (src_req) begin
            state <= FLUSH;
          end else if (!beat_held) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end
        end
        DONE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (!net_flush) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/dfd_trace_arb.sv
// Weighted round-robin arbiter sharing one trace-network output among several packetizers,
// with flush-aware priority and a registered output beat.
module dfd_trace_arb
  import dfd_trace_arb_pkg::*;
#(
  parameter  int unsigned NUM_SRC             = 2,
  parameter  int unsigned DATA_WIDTH_IN_BYTES = 16,
  parameter  int unsigned WEIGHT_WIDTH        = 4,
  localparam int unsigned DATA_W              = DATA_WIDTH_IN_BYTES * 8,
  localparam int unsigned SRC_ID_W            = src_id_width(NUM_SRC)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            arb_enable_in,
  input  logic [NUM_SRC*WEIGHT_WIDTH-1:0] weight_in,
  input  logic [NUM_SRC-1:0]              src_req_in,
  input  logic [NUM_SRC*DATA_W-1:0]       src_data_in,
  output logic [NUM_SRC-1:0]              src_pull_out,
  input  logic [NUM_SRC-1:0]              net_flush_in,
  input  logic [NUM_SRC-1:0]              net_bp_in,
  output logic [NUM_SRC-1:0]              hw_flush_out,
  output logic [NUM_SRC-1:0]              hw_stop_out,
  output logic [NUM_SRC-1:0]              flush_done_out,
  input  logic                            tr_gnt_in,
  output logic                            tr_vld_out,
  output logic [SRC_ID_W-1:0]             tr_src_out,
  output logic [DATA_W-1:0]               tr_data_out
);

  logic [NUM_SRC-1:0]      eligible_c;
  logic [NUM_SRC-1:0]      active_c;
  logic [NUM_SRC-1:0]      flush_pri_c;
  logic [NUM_SRC-1:0]      held_c;
  logic [SRC_ID_W-1:0]     owner;
  logic [WEIGHT_WIDTH-1:0] beat_cnt;
  logic [WEIGHT_WIDTH-1:0] owner_weight_c;
  logic [SRC_ID_W-1:0]     sel_c;
  logic                    hit_c;
  logic                    load_c;
  logic [DATA_W-1:0]       sel_data_c;

  assign eligible_c     = src_req_in & ~net_bp_in;
  assign flush_pri_c    = eligible_c & active_c;
  assign owner_weight_c = weight_in[32'(owner)*WEIGHT_WIDTH +: WEIGHT_WIDTH];

  // Picker: flushing sources first, then the owner within its weight, then rotate from owner+1.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    sel_c = owner;
    hit_c = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!hit_c && flush_pri_c[i]) begin
        sel_c = SRC_ID_W'(i);
        hit_c = 1'b1;
      end
    end
    if (!hit_c && eligible_c[owner] && (beat_cnt < owner_weight_c)) begin
      sel_c = owner;
      hit_c = 1'b1;
    end
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = (32'(owner) + k) % NUM_SRC;
      if (!hit_c && eligible_c[idx]) begin
        sel_c = SRC_ID_W'(idx);
        hit_c = 1'b1;
      end
    end
  end

  assign load_c     = reset_n & (~tr_vld_out | tr_gnt_in) & arb_enable_in & hit_c;
  assign sel_data_c = src_data_in[32'(sel_c)*DATA_W +: DATA_W];

  // The pop pulse must coincide with the capture, so it is decoded directly from the load.
  always_comb begin
    src_pull_out = '0;
    if (load_c) src_pull_out[sel_c] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner       <= '0;
      beat_cnt    <= '0;
      tr_vld_out  <= 1'b0;
      tr_src_out  <= '0;
      tr_data_out <= '0;
    end else if (load_c) begin
      tr_vld_out  <= 1'b1;
      tr_src_out  <= sel_c;
      tr_data_out <= sel_data_c;
      if (sel_c != owner) begin
        owner    <= sel_c;
        beat_cnt <= '0;
      end else if (beat_cnt != '1) begin
        beat_cnt <= beat_cnt + WEIGHT_WIDTH'(1);
      end
    end else if (tr_gnt_in) begin
      tr_vld_out <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_flush
    assign held_c[i] = tr_vld_out && (tr_src_out == SRC_ID_W'(i));

    dfd_trace_flush_seq u_seq (
      .clk            (clk),
      .reset_n        (reset_n),
      .net_flush      (net_flush_in[i]),
      .net_bp         (net_bp_in[i]),
      .src_req        (src_req_in[i]),
      .beat_held      (held_c[i]),
      .hw_flush       (hw_flush_out[i]),
      .hw_stop        (hw_stop_out[i]),
      .flush_done     (flush_done_out[i]),
      .flush_active_c (active_c[i])
    );
  end

endmodule
